// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII receive frame parser.
// FSM states, framing bytes, length width and the frame-status record.
package gmii_rx_pkg;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] PTP_ETYPE_DFLT = 16'h88F7;
  localparam int          LEN_W         = 16;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             runt;
    logic             long_err;
  } rx_stat_t;

endpackage

// File: rtl/gmii_rx_frame_parser_if.sv
// GMII RX input bus plus the parsed frame stream and status; master drives the PHY side,
// slave is the parser. No backpressure anywhere on this bus.
interface gmii_rx_frame_parser_if;

  logic                         gmii_rxctrl;
  logic [7:0]                   gmii_rxdata;
  logic                         rx_sfd;
  logic [7:0]                   rx_data;
  logic                         rx_valid;
  logic                         rx_sop;
  logic                         rx_eop;
  logic                         rx_done;
  logic [gmii_rx_pkg::LEN_W-1:0] rx_len;
  logic                         rx_err_runt;
  logic                         rx_err_long;
  logic                         ptp_hit;
  logic [3:0]                   ptp_msgtype;

  modport master (
    output gmii_rxctrl, gmii_rxdata,
    input  rx_sfd, rx_data, rx_valid, rx_sop, rx_eop, rx_done,
    input  rx_len, rx_err_runt, rx_err_long, ptp_hit, ptp_msgtype
  );

  modport slave (
    input  gmii_rxctrl, gmii_rxdata,
    output rx_sfd, rx_data, rx_valid, rx_sop, rx_eop, rx_done,
    output rx_len, rx_err_runt, rx_err_long, ptp_hit, ptp_msgtype
  );

endinterface

// File: rtl/gmii_rx_ptp_detect.sv
// L2 PTP classifier on the emitted byte stream; ptp_hit is combinational from the stream
// registers, in the same cycle byte 14 is on the stream. No backpressure.
module gmii_rx_ptp_detect
  import gmii_rx_pkg::*;
#(
  parameter logic [15:0] PTP_ETYPE = PTP_ETYPE_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_vld,
  input  logic       byte_sop,
  input  logic [7:0] byte_dat,
  output logic       ptp_hit,
  output logic [3:0] ptp_msgtype
);

  logic [4:0] idx;
  logic [4:0] cur_idx;
  logic       hi_match;
  logic       etype_match;

  assign cur_idx = byte_sop ? 5'd0 : idx;

  // idx saturates at 31 so byte 14 is seen at most once per frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx         <= 5'd0;
      hi_match    <= 1'b0;
      etype_match <= 1'b0;
    end else if (byte_vld) begin
      idx <= (cur_idx == 5'd31) ? cur_idx : cur_idx + 5'd1;
      if (cur_idx == 5'd12) hi_match <= (byte_dat == PTP_ETYPE[15:8]);
      if (cur_idx == 5'd13) etype_match <= hi_match && (byte_dat == PTP_ETYPE[7:0]);
    end
  end

  assign ptp_hit     = byte_vld && (cur_idx == 5'd14) && etype_match;
  assign ptp_msgtype = ptp_hit ? byte_dat[3:0] : 4'h0;

endmodule

// File: rtl/gmii_rx_frame_parser.sv
// GMII RX front end: preamble/SFD check, frame byte stream, length/error status; optional PTP
// detect under GMII_RX_PTP_DETECT_EN. Input to rx_data is 2 cycles; no backpressure.
module gmii_rx_frame_parser
  import gmii_rx_pkg::*;
#(
  parameter int MIN_PREAMBLE = 7,
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1522
`ifdef GMII_RX_PTP_DETECT_EN
  , parameter logic [15:0] PTP_ETYPE = PTP_ETYPE_DFLT
`endif
) (
  input  logic                  gmii_rxclk,
  input  logic                  rst_n,
  gmii_rx_frame_parser_if.slave bus
);

  localparam logic [3:0]       MIN_PRE = 4'(MIN_PREAMBLE);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME);

  rx_state_t        state;
  logic             s1_ctrl;
  logic [7:0]       s1_dat;
  logic [3:0]       pcnt;
  logic [7:0]       hold_dat;
  logic             hold_vld;
  logic             sop_pend;
  logic             done_pend;
  logic [LEN_W-1:0] len_cnt;

  logic             sfd_q, vld_q, sop_q, eop_q, done_q;
  logic [7:0]       dat_q;
  rx_stat_t         stat_q;

  always_ff @(posedge gmii_rxclk) begin
    if (!rst_n) begin
      state     <= IDLE;
      s1_ctrl   <= 1'b0;
      s1_dat    <= 8'h00;
      pcnt      <= 4'd0;
      hold_dat  <= 8'h00;
      hold_vld  <= 1'b0;
      sop_pend  <= 1'b0;
      done_pend <= 1'b0;
      len_cnt   <= '0;
      sfd_q     <= 1'b0;
      vld_q     <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      done_q    <= 1'b0;
      dat_q     <= 8'h00;
      stat_q    <= '0;
    end else begin
      s1_ctrl   <= bus.gmii_rxctrl;
      s1_dat    <= bus.gmii_rxdata;
      sfd_q     <= 1'b0;
      vld_q     <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      dat_q     <= 8'h00;
      // status trails eop by one cycle; len_cnt is only cleared at the next SFD
      done_q    <= done_pend;
      done_pend <= 1'b0;
      if (done_pend) begin
        stat_q.len      <= len_cnt;
        stat_q.runt     <= (len_cnt < MIN_LEN);
        stat_q.long_err <= (len_cnt > MAX_LEN);
      end else begin
        stat_q <= '0;
      end

      case (state)
        IDLE: begin
          if (s1_ctrl) begin
            if (s1_dat == PREAMBLE_BYTE) begin
              state <= PREAMBLE;
              pcnt  <= 4'd1;
            end else begin
              state <= DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!s1_ctrl) begin
            state <= IDLE;
          end else if (s1_dat == PREAMBLE_BYTE) begin
            if (pcnt != 4'hF) pcnt <= pcnt + 4'd1;
          end else if (s1_dat == SFD_BYTE && pcnt >= MIN_PRE) begin
            state    <= DATA;
            sfd_q    <= 1'b1;
            sop_pend <= 1'b1;
            hold_vld <= 1'b0;
            len_cnt  <= '0;
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          // one-byte holding stage lets eop ride with the last byte when ctrl drops
          if (hold_vld) begin
            vld_q    <= 1'b1;
            dat_q    <= hold_dat;
            sop_q    <= sop_pend;
            eop_q    <= !s1_ctrl;
            sop_pend <= 1'b0;
          end
          if (s1_ctrl) begin
            hold_dat <= s1_dat;
            hold_vld <= 1'b1;
            if (len_cnt != '1) len_cnt <= len_cnt + 1'b1;
          end else begin
            hold_vld  <= 1'b0;
            done_pend <= 1'b1;
            state     <= IDLE;
          end
        end
        DROP: begin
          if (!s1_ctrl) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_sfd      = sfd_q;
  assign bus.rx_data     = dat_q;
  assign bus.rx_valid    = vld_q;
  assign bus.rx_sop      = sop_q;
  assign bus.rx_eop      = eop_q;
  assign bus.rx_done     = done_q;
  assign bus.rx_len      = stat_q.len;
  assign bus.rx_err_runt = stat_q.runt;
  assign bus.rx_err_long = stat_q.long_err;

  logic       ptp_hit_w;
  logic [3:0] ptp_mt_w;

`ifdef GMII_RX_PTP_DETECT_EN
  gmii_rx_ptp_detect #(.PTP_ETYPE(PTP_ETYPE)) u_ptp_detect (
    .clk        (gmii_rxclk),
    .rst_n      (rst_n),
    .byte_vld   (vld_q),
    .byte_sop   (sop_q),
    .byte_dat   (dat_q),
    .ptp_hit    (ptp_hit_w),
    .ptp_msgtype(ptp_mt_w)
  );
`else
  assign ptp_hit_w = 1'b0;
  assign ptp_mt_w  = 4'h0;
`endif

  assign bus.ptp_hit     = ptp_hit_w;
  assign bus.ptp_msgtype = ptp_mt_w;

endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Directed frame table plus hand sequences (reset state, back-to-back, reset mid-frame)
// for gmii_rx_frame_parser; a negedge monitor accumulates what the stream carried.
module tb_gmii_rx_frame_parser;
  import gmii_rx_pkg::*;

`ifdef GMII_RX_PTP_DETECT_EN
  localparam int PTP_ON = 1;
`else
  localparam int PTP_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  gmii_rx_frame_parser_if bus();

  gmii_rx_frame_parser dut (
    .gmii_rxclk(clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  typedef struct {
    int         npre;
    logic [7:0] sfd;
    int         nbytes;
    bit         ptp;
    logic [7:0] b14;
    int         e_sfd;
    int         e_beats;
    int         e_len;
    int         e_runt;
    int         e_long;
    int         e_ptp;
  } vec_t;

  vec_t vecs[14];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  bit         cur_ptp = 1'b0;
  logic [7:0] cur_b14 = 8'h00;
  int         d_sfd_cyc = 0;
  int         d_first_cyc = 0;

  int c_sfd = 0, c_beats = 0, c_sop = 0, c_eop = 0, c_done = 0, c_derr = 0, c_ptp = 0;
  int l_len = 0, l_runt = 0, l_long = 0, l_mt = 0, l_ptp_idx = 0, l_eop_idx = 0;
  int l_sfd_cyc = 0, l_sop_cyc = 0, l_eop_cyc = 0, l_done_cyc = 0;
  int bidx = 0;

  always @(posedge clk) cyc++;

  function automatic logic [7:0] exp_byte(input int i);
    if (cur_ptp && i == 12) return 8'h88;
    if (cur_ptp && i == 13) return 8'hF7;
    if (cur_ptp && i == 14) return cur_b14;
    return 8'(i);
  endfunction

  always @(negedge clk) begin
    if (bus.rx_sfd) begin
      c_sfd++;
      l_sfd_cyc = cyc;
    end
    if (bus.rx_valid) begin
      if (bus.rx_sop) begin
        bidx = 0;
        c_sop++;
        l_sop_cyc = cyc;
      end
      if (bus.rx_data !== exp_byte(bidx)) c_derr++;
      if (bus.rx_eop) begin
        c_eop++;
        l_eop_idx = bidx;
        l_eop_cyc = cyc;
      end
      c_beats++;
      bidx++;
    end
    if (bus.ptp_hit) begin
      c_ptp++;
      l_mt      = int'(bus.ptp_msgtype);
      l_ptp_idx = bidx - 1;
    end
    if (bus.rx_done) begin
      c_done++;
      l_len      = int'(bus.rx_len);
      l_runt     = int'(bus.rx_err_runt);
      l_long     = int'(bus.rx_err_long);
      l_done_cyc = cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.gmii_rxctrl = c;
    bus.gmii_rxdata = d;
  endtask

  task automatic send_frame(input int npre, input logic [7:0] sfd, input int nbytes,
                            input bit ptp, input logic [7:0] b14, input int gap);
    cur_ptp = ptp;
    cur_b14 = b14;
    repeat (npre) drive(1'b1, 8'h55);
    drive(1'b1, sfd);
    d_sfd_cyc = cyc;
    for (int i = 0; i < nbytes; i++) begin
      drive(1'b1, exp_byte(i));
      if (i == 0) d_first_cyc = cyc;
    end
    repeat (gap) drive(1'b0, 8'h00);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int b_sfd, b_beats, b_sop, b_eop, b_done, b_derr, b_ptp;
    b_sfd = c_sfd; b_beats = c_beats; b_sop = c_sop; b_eop = c_eop;
    b_done = c_done; b_derr = c_derr; b_ptp = c_ptp;
    send_frame(v.npre, v.sfd, v.nbytes, v.ptp, v.b14, 8);
    check($sformatf("v%0d sfd_count", k), c_sfd - b_sfd, v.e_sfd);
    check($sformatf("v%0d beats", k), c_beats - b_beats, v.e_beats);
    check($sformatf("v%0d sop_count", k), c_sop - b_sop, (v.e_beats > 0) ? 1 : 0);
    check($sformatf("v%0d eop_count", k), c_eop - b_eop, (v.e_beats > 0) ? 1 : 0);
    check($sformatf("v%0d done_count", k), c_done - b_done, v.e_sfd);
    check($sformatf("v%0d data_errors", k), c_derr - b_derr, 0);
    check($sformatf("v%0d ptp_hits", k), c_ptp - b_ptp, v.e_ptp);
    if (v.e_sfd > 0) begin
      check($sformatf("v%0d rx_len", k), l_len, v.e_len);
      check($sformatf("v%0d runt", k), l_runt, v.e_runt);
      check($sformatf("v%0d long", k), l_long, v.e_long);
      check($sformatf("v%0d sfd_latency", k), l_sfd_cyc - d_sfd_cyc, 2);
    end
    if (v.e_beats > 0) begin
      check($sformatf("v%0d sop_latency", k), l_sop_cyc - d_first_cyc, 3);
      check($sformatf("v%0d eop_index", k), l_eop_idx, v.e_beats - 1);
      check($sformatf("v%0d done_after_eop", k), l_done_cyc - l_eop_cyc, 1);
    end
    if (v.e_ptp > 0) begin
      check($sformatf("v%0d ptp_msgtype", k), l_mt, int'(v.b14[3:0]));
      check($sformatf("v%0d ptp_byte_index", k), l_ptp_idx, 14);
    end
  endtask

  initial begin
    int b_sfd, b_beats, b_eop, b_done, b_derr;

    //          npre sfd    nbytes ptp b14    sfd beats len  runt long ptp
    vecs[0]  = '{7,  8'hD5, 64,   0, 8'h00, 1,  64,   64,   0, 0, 0};
    vecs[1]  = '{5,  8'hD5, 64,   0, 8'h00, 0,  0,    0,    0, 0, 0};
    vecs[2]  = '{7,  8'hD5, 60,   0, 8'h00, 1,  60,   60,   1, 0, 0};
    vecs[3]  = '{7,  8'hD5, 1600, 0, 8'h00, 1,  1600, 1600, 0, 1, 0};
    vecs[4]  = '{7,  8'hD5, 64,   1, 8'h01, 1,  64,   64,   0, 0, PTP_ON};
    vecs[5]  = '{7,  8'hD5, 0,    0, 8'h00, 1,  0,    0,    1, 0, 0};
    vecs[6]  = '{8,  8'hD5, 1,    0, 8'h00, 1,  1,    1,    1, 0, 0};
    vecs[7]  = '{7,  8'hAA, 64,   0, 8'h00, 0,  0,    0,    0, 0, 0};
    vecs[8]  = '{7,  8'hD5, 14,   1, 8'h03, 1,  14,   14,   1, 0, 0};
    vecs[9]  = '{20, 8'hD5, 20,   1, 8'hAB, 1,  20,   20,   1, 0, PTP_ON};
    vecs[10] = '{7,  8'hD5, 63,   0, 8'h00, 1,  63,   63,   1, 0, 0};
    vecs[11] = '{7,  8'hD5, 1522, 0, 8'h00, 1,  1522, 1522, 0, 0, 0};
    vecs[12] = '{7,  8'hD5, 1523, 0, 8'h00, 1,  1523, 1523, 0, 1, 0};
    vecs[13] = '{6,  8'hD5, 64,   0, 8'h00, 0,  0,    0,    0, 0, 0};

    bus.gmii_rxctrl = 1'b0;
    bus.gmii_rxdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_output_ones",
          $countones({bus.rx_sfd, bus.rx_data, bus.rx_valid, bus.rx_sop, bus.rx_eop,
                      bus.rx_done, bus.rx_len, bus.rx_err_runt, bus.rx_err_long,
                      bus.ptp_hit, bus.ptp_msgtype}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) drive(1'b0, 8'h00);

    for (int k = 0; k < 14; k++) run_vec(k, vecs[k]);

    // back-to-back frames with a single idle cycle between them
    b_sfd = c_sfd; b_beats = c_beats; b_done = c_done; b_derr = c_derr;
    send_frame(7, 8'hD5, 64, 1'b0, 8'h00, 1);
    send_frame(7, 8'hD5, 64, 1'b0, 8'h00, 8);
    check("b2b sfd_count", c_sfd - b_sfd, 2);
    check("b2b beats", c_beats - b_beats, 128);
    check("b2b done_count", c_done - b_done, 2);
    check("b2b rx_len", l_len, 64);
    check("b2b data_errors", c_derr - b_derr, 0);

    // one-cycle reset at byte 30 of a 100-byte frame
    cur_ptp = 1'b0;
    b_sfd = 0; b_beats = 0; b_eop = 0; b_done = 0;
    repeat (7) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, exp_byte(i));
      if (i == 30) rst_n = 1'b0;
      if (i == 31) begin
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_output_ones",
              $countones({bus.rx_sfd, bus.rx_data, bus.rx_valid, bus.rx_sop, bus.rx_eop,
                          bus.rx_done, bus.rx_len, bus.rx_err_runt, bus.rx_err_long,
                          bus.ptp_hit, bus.ptp_msgtype}), 0);
        b_sfd = c_sfd; b_beats = c_beats; b_eop = c_eop; b_done = c_done;
      end
    end
    repeat (8) drive(1'b0, 8'h00);
    check("midreset eop_count", c_eop - b_eop, 0);
    check("midreset done_count", c_done - b_done, 0);
    check("midreset beats", c_beats - b_beats, 0);
    check("midreset sfd_count", c_sfd - b_sfd, 0);
    run_vec(99, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gmii_rx_frame_parser.md
Name: gmii_rx_frame_parser

Overview:
Synthesizable GMII receive front end in the TSU receive path, directly downstream of the GMII PHY interface (driven by the GMII RX bus-functional model in simulation).
- Validates preamble/SFD and strips them.
- Emits frame bytes with sop/eop framing.
- Pulses a timestamp-capture strobe at SFD.
- Reports frame length and errors.
- Optionally classifies layer-2 PTP frames.

Parameters:
- MIN_PREAMBLE, 7: minimum 0x55 bytes before 0xD5 for a valid SFD.
- MIN_FRAME, 64: shorter frames flag runt (length includes FCS).
- MAX_FRAME, 1522: longer frames flag oversize.
- PTP_ETYPE, 16'h88F7: EtherType identifying L2 PTP.

Ports:
- gmii_rxclk   in   1   receive clock, 125 MHz; sole clock.
- rst_n        in   1   synchronous active-low reset.
- gmii_rxctrl  in   1   RX_DV.
- gmii_rxdata  in   8   RXD.
- rx_sfd       out  1   one-cycle pulse; SFD byte was sampled (timestamp point).
- rx_data      out  8   frame byte (DA first, FCS last).
- rx_valid     out  1   rx_data valid.
- rx_sop       out  1   first frame byte (with rx_valid).
- rx_eop       out  1   last frame byte (with rx_valid).
- rx_done      out  1   one-cycle frame-status pulse.
- rx_len       out  16  byte count, valid with rx_done.
- rx_err_runt  out  1   valid with rx_done.
- rx_err_long  out  1   valid with rx_done.
- ptp_hit      out  1   one-cycle pulse; PTP frame detected (feature only).
- ptp_msgtype  out  4   PTP messageType, valid with ptp_hit.

Behaviour:
Decided: one clock; reset is synchronous and active-low; clock port gmii_rxclk, reset port rst_n.

Reset:
- All outputs 0.
- State IDLE; counters 0; holding register empty.

Input:
- gmii_rxctrl/gmii_rxdata registered once on posedge gmii_rxclk (stage S1).
- FSM operates on S1.

FSM:
- IDLE:
  - ctrl=1 & data=0x55 -> PREAMBLE, pcnt=1.
  - ctrl=1 & other data -> DROP.
  - ctrl=0 -> stay.
- PREAMBLE:
  - 0x55 -> pcnt++ (saturates at 15).
  - 0xD5 & pcnt>=MIN_PREAMBLE -> DATA; rx_sfd=1 for this cycle.
  - 0xD5 with short preamble, or any other byte -> DROP.
  - ctrl=0 -> IDLE; no outputs.
- DATA:
  - ctrl=1 -> byte into holding register; the previously held byte goes out with rx_valid.
  - ctrl=0 -> held byte goes out with rx_valid & rx_eop; next cycle rx_done pulses; -> IDLE.
- DROP: discard until ctrl=0 -> IDLE; no outputs, no rx_done.

Output rules:
- rx_sop accompanies the first byte emitted after SFD.
- A single-byte frame asserts rx_sop and rx_eop together.
- Latency: input byte at edge N appears on rx_data at edge N+2. rx_sfd lags the SFD byte by 1 cycle.
- Zero-byte frame (ctrl falls right after SFD): no rx_valid; rx_done with rx_len=0, rx_err_runt=1.

Length and errors:
- rx_len counts bytes after SFD, 16-bit, saturates at 16'hFFFF; no wrap.
- rx_err_runt = rx_len<MIN_FRAME.
- rx_err_long = rx_len>MAX_FRAME.
- No gap is required between frames: the SFD-detect path of the next frame may run in the same cycle as rx_done of the previous one.

Reset mid-frame:
- Outputs clear next cycle; no eop/rx_done is emitted for the aborted frame.
- The remainder of that frame is discarded. If it resumes with 0x55, parsing restarts from PREAMBLE, and a spurious frame is accepted only if a valid SFD follows.

Optional Feature:
Macro GMII_RX_PTP_DETECT_EN.
- Defined:
  - Bytes 12-13 (0-based after SFD) compared to PTP_ETYPE.
  - On match, byte 14 low nibble is captured; ptp_hit pulses in the cycle byte 14 is emitted on rx_data, with ptp_msgtype = messageType.
  - At most one ptp_hit per frame; none for frames shorter than 15 bytes.
  - VLAN-tagged frames are not detected.
- Undefined: ptp_hit and ptp_msgtype tied 0; no comparator logic.

Decomposition:
- Package gmii_rx_pkg holds:
  - FSM state typedef (IDLE, PREAMBLE, DATA, DROP);
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5;
  - default PTP_ETYPE;
  - width constant LEN_W=16.
- One sub-module, gmii_rx_ptp_detect: byte index, EtherType compare, msgtype capture. Instantiated only under the macro.

Test Plan:
1. 7×0x55, 0xD5, 64 bytes 00..3F, ctrl drop -> rx_sfd one pulse; 64 rx_valid beats, sop on 0x00, eop on 0x3F; rx_done with rx_len=64, no errors.
2. 5×0x55 then 0xD5 -> DROP; no rx_sfd, no rx_valid, no rx_done.
3. 60-byte frame, then 1600-byte frame -> first: rx_err_runt=1, rx_len=60; second: rx_err_long=1, rx_len=1600.
4. Frame with bytes 12-13 = 88 F7 and byte 14 = 0x01 -> ptp_hit once, ptp_msgtype=1 with byte 14 on rx_data (macro on); ptp_hit stays 0 with macro off.
5. rst_n low for 1 cycle at byte 30 of a 100-byte frame -> outputs 0; no eop or rx_done for that frame; the following correct frame parses normally.
6. SFD immediately followed by ctrl=0 -> rx_sfd pulse; rx_done with rx_len=0, rx_err_runt=1; no rx_valid.
